dram_controller: RTL and testbench

- Sequences FPM DRAM for 68040 bus cycles that decode into DRAM space (dramsel, 0x0000_0000–0x1FFF_FFFF).
- Generates multiplexed row/column address, nRAS, per-lane nCAS, nWE and the bus acknowledge nTA.
- Supports single transfers and 4-beat line bursts.
- Arbitrates the DRAM between bus cycles and a periodic CAS-before-RAS refresh engine.

---
 rtl/dram_controller.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_dram_controller.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_controller.sv
// FPM DRAM controller for 68040 bus cycles: row/column sequencing, single and
// 4-beat line transfers, and a CAS-before-RAS refresh engine sharing the array.
module dram_controller #(
  parameter int unsigned ROW_W            = 11,
  parameter int unsigned COL_W            = 11,
  parameter int unsigned T_RCD            = 2,
  parameter int unsigned T_CAS            = 2,
  parameter int unsigned T_RP             = 2,
  parameter int unsigned T_RAS_REF        = 4,
  parameter int unsigned REFRESH_INTERVAL = 390
) (
  input  logic                   BCLK,
  input  logic                   RESET,
  input  logic                   nTS,
  input  logic                   dramsel,
  input  logic                   RnW,
  input  logic [1:0]             SIZ,
  input  logic [3:0]             BE,
  input  logic [ROW_W+COL_W-1:0] ADDR,
  output logic [ROW_W-1:0]       MA,
  output logic                   nRAS,
  output logic [3:0]             nCAS,
  output logic                   nWE,
  output logic                   nTA,
  output logic                   busy
);

  localparam int unsigned AddrW = ROW_W + COL_W;
  localparam int unsigned MaxA  = (T_RCD > T_CAS) ? T_RCD : T_CAS;
  localparam int unsigned MaxB  = (T_RP > T_RAS_REF) ? T_RP : T_RAS_REF;
  localparam int unsigned MaxT  = (MaxA > MaxB) ? MaxA : MaxB;
  localparam int unsigned CntW  = $clog2(MaxT + 1);
  localparam int unsigned RefW  = $clog2(REFRESH_INTERVAL);

  typedef enum logic [2:0] {
    StIdle, StRow, StCol, StCpre, StPre, StRefCas, StRefRas, StRefPre
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [1:0]        beat_q, beat_d;
  logic [RefW-1:0]   ref_cnt_q, ref_cnt_d;
  logic              ref_pending_q, ref_pending_d;
  logic              req_pending_q, req_pending_d;

  // Pending request (captured on every decoded nTS)
  logic              p_rnw_q, p_rnw_d;
  logic              p_line_q, p_line_d;
  logic [3:0]        p_be_q, p_be_d;
  logic [AddrW-1:0]  p_addr_q, p_addr_d;

  // Active request (loaded on entry to ROW, stable for the whole cycle)
  logic              a_rnw_q, a_rnw_d;
  logic              a_line_q, a_line_d;
  logic [3:0]        a_be_q, a_be_d;
  logic [ROW_W-1:0]  a_row_q, a_row_d;
  logic [COL_W-1:0]  a_col_q, a_col_d;

  logic [ROW_W-1:0]  ma_q, ma_d;
  logic              nras_q, nras_d;
  logic [3:0]        ncas_q, ncas_d;
  logic              nwe_q, nwe_d;
  logic              nta_q, nta_d;
  logic              busy_q, busy_d;

  logic cap, ref_exp, enter_row, enter_ref, take_live;

  assign cap     = !nTS && dramsel;
  assign ref_exp = (ref_cnt_q == '0);

  // Refresh timer and request capture bookkeeping
  always_comb begin
    ref_cnt_d = ref_exp ? RefW'(REFRESH_INTERVAL - 1) : ref_cnt_q - 1'b1;
    // Consuming the refresh in IDLE also covers an expiry on that same edge
    if (enter_ref)    ref_pending_d = 1'b0;
    else if (ref_exp) ref_pending_d = 1'b1;
    else              ref_pending_d = ref_pending_q;

    p_rnw_d  = p_rnw_q;
    p_line_d = p_line_q;
    p_be_d   = p_be_q;
    p_addr_d = p_addr_q;
    if (cap) begin
      p_rnw_d  = RnW;
      p_line_d = (SIZ == 2'b11);
      p_be_d   = BE;
      p_addr_d = ADDR;
    end
    // A live request taken straight from IDLE is consumed, not left pending
    if (cap && !(enter_row && take_live)) req_pending_d = 1'b1;
    else if (enter_row)                   req_pending_d = 1'b0;
    else                                  req_pending_d = req_pending_q;
  end

  // Main sequencer: next state, dwell counter, beat and column walk
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    beat_d    = beat_q;
    a_rnw_d   = a_rnw_q;
    a_line_d  = a_line_q;
    a_be_d    = a_be_q;
    a_row_d   = a_row_q;
    a_col_d   = a_col_q;
    enter_row = 1'b0;
    enter_ref = 1'b0;
    take_live = !req_pending_q;
    unique case (state_q)
      StIdle: begin
        if (ref_pending_q || ref_exp) begin
          state_d   = StRefCas;
          cnt_d     = '0;
          enter_ref = 1'b1;
        end else if (req_pending_q || cap) begin
          state_d   = StRow;
          cnt_d     = CntW'(T_RCD - 1);
          beat_d    = 2'd0;
          enter_row = 1'b1;
          if (take_live) begin
            a_rnw_d  = RnW;
            a_line_d = (SIZ == 2'b11);
            a_be_d   = BE;
            a_row_d  = ADDR[AddrW-1:COL_W];
            a_col_d  = ADDR[COL_W-1:0];
          end else begin
            a_rnw_d  = p_rnw_q;
            a_line_d = p_line_q;
            a_be_d   = p_be_q;
            a_row_d  = p_addr_q[AddrW-1:COL_W];
            a_col_d  = p_addr_q[COL_W-1:0];
          end
        end
      end
      StRow: begin
        if (cnt_q == '0) begin
          state_d = StCol;
          cnt_d   = CntW'(T_CAS - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StCol: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (a_line_q && beat_q != 2'd3) begin
          state_d = StCpre;
          cnt_d   = '0;
        end else begin
          state_d = StPre;
          cnt_d   = CntW'(T_RP - 1);
        end
      end
      StCpre: begin
        // Line bursts wrap within the aligned 4-longword line
        state_d      = StCol;
        cnt_d        = CntW'(T_CAS - 1);
        beat_d       = beat_q + 2'd1;
        a_col_d[1:0] = a_col_q[1:0] + 2'd1;
      end
      StPre: begin
        if (cnt_q == '0) state_d = StIdle;
        else             cnt_d   = cnt_q - 1'b1;
      end
      StRefCas: begin
        state_d = StRefRas;
        cnt_d   = CntW'(T_RAS_REF - 1);
      end
      StRefRas: begin
        if (cnt_q == '0) begin
          state_d = StRefPre;
          cnt_d   = CntW'(T_RP - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StRefPre: begin
        if (cnt_q == '0) state_d = StIdle;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  // Output decode from next state so the DRAM strobes come straight off flops
  always_comb begin
    ma_d   = ma_q;
    nras_d = 1'b1;
    ncas_d = 4'hF;
    nwe_d  = 1'b1;
    nta_d  = 1'b1;
    busy_d = (state_d != StIdle);
    unique case (state_d)
      StRow: begin
        ma_d   = a_row_d;
        nras_d = 1'b0;
      end
      StCol: begin
        ma_d   = ROW_W'(a_col_d);
        nras_d = 1'b0;
        ncas_d = (a_rnw_d || a_line_d) ? 4'h0 : ~a_be_d;
        nwe_d  = a_rnw_d;
        nta_d  = (cnt_d != '0);
      end
      StCpre: begin
        ma_d   = ROW_W'(a_col_d);
        nras_d = 1'b0;
        nwe_d  = a_rnw_d;
      end
      StRefCas: ncas_d = 4'h0;
      StRefRas: begin
        ncas_d = 4'h0;
        nras_d = 1'b0;
      end
      StIdle, StPre, StRefPre: ;
      default: ;
    endcase
  end

  // State, request and refresh registers
  always_ff @(posedge BCLK) begin
    if (RESET) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      beat_q        <= 2'd0;
      ref_cnt_q     <= RefW'(REFRESH_INTERVAL - 1);
      ref_pending_q <= 1'b0;
      req_pending_q <= 1'b0;
      p_rnw_q       <= 1'b1;
      p_line_q      <= 1'b0;
      p_be_q        <= 4'h0;
      p_addr_q      <= '0;
      a_rnw_q       <= 1'b1;
      a_line_q      <= 1'b0;
      a_be_q        <= 4'h0;
      a_row_q       <= '0;
      a_col_q       <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      beat_q        <= beat_d;
      ref_cnt_q     <= ref_cnt_d;
      ref_pending_q <= ref_pending_d;
      req_pending_q <= req_pending_d;
      p_rnw_q       <= p_rnw_d;
      p_line_q      <= p_line_d;
      p_be_q        <= p_be_d;
      p_addr_q      <= p_addr_d;
      a_rnw_q       <= a_rnw_d;
      a_line_q      <= a_line_d;
      a_be_q        <= a_be_d;
      a_row_q       <= a_row_d;
      a_col_q       <= a_col_d;
    end
  end

  // Registered DRAM and bus outputs
  always_ff @(posedge BCLK) begin
    if (RESET) begin
      ma_q   <= '0;
      nras_q <= 1'b1;
      ncas_q <= 4'hF;
      nwe_q  <= 1'b1;
      nta_q  <= 1'b1;
      busy_q <= 1'b0;
    end else begin
      ma_q   <= ma_d;
      nras_q <= nras_d;
      ncas_q <= ncas_d;
      nwe_q  <= nwe_d;
      nta_q  <= nta_d;
      busy_q <= busy_d;
    end
  end

  assign MA   = ma_q;
  assign nRAS = nras_q;
  assign nCAS = ncas_q;
  assign nWE  = nwe_q;
  assign nTA  = nta_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_dram_controller.sv
// Directed bench for dram_controller: reset, single read, byte write, line
// burst, decode miss, refresh interval and refresh/request collision.
module tb_dram_controller;

  logic        BCLK = 1'b0;
  logic        RESET = 1'b1;
  logic        nTS = 1'b1;
  logic        dramsel = 1'b0;
  logic        RnW = 1'b1;
  logic [1:0]  SIZ = 2'b00;
  logic [3:0]  BE = 4'h0;
  logic [21:0] ADDR = '0;
  logic [10:0] MA;
  logic        nRAS;
  logic [3:0]  nCAS;
  logic        nWE;
  logic        nTA;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic        tr_nras [1:32];
  logic [3:0]  tr_ncas [1:32];
  logic        tr_nwe  [1:32];
  logic        tr_nta  [1:32];
  logic        tr_busy [1:32];
  logic [10:0] tr_ma   [1:32];

  dram_controller dut (
    .BCLK    (BCLK),
    .RESET   (RESET),
    .nTS     (nTS),
    .dramsel (dramsel),
    .RnW     (RnW),
    .SIZ     (SIZ),
    .BE      (BE),
    .ADDR    (ADDR),
    .MA      (MA),
    .nRAS    (nRAS),
    .nCAS    (nCAS),
    .nWE     (nWE),
    .nTA     (nTA),
    .busy    (busy)
  );

  always #5 BCLK = ~BCLK;

  // Hold reset for two edges; returns at the negedge after the last reset edge
  task automatic do_reset();
    @(negedge BCLK);
    RESET = 1'b1;
    repeat (2) @(posedge BCLK);
    @(negedge BCLK);
    RESET = 1'b0;
  endtask

  // Present one nTS for a single edge (edge 0); returns at the negedge after it
  task automatic issue(input logic rnw, input logic [1:0] siz, input logic [3:0] be,
                       input logic [21:0] addr, input logic sel);
    @(negedge BCLK);
    nTS = 1'b0; dramsel = sel; RnW = rnw; SIZ = siz; BE = be; ADDR = addr;
    @(negedge BCLK);
    nTS = 1'b1; dramsel = 1'b0;
  endtask

  // Record outputs for n cycles; cycle 1 is the current negedge
  task automatic capture(input int n);
    for (int k = 1; k <= n; k++) begin
      if (k > 1) @(negedge BCLK);
      tr_nras[k] = nRAS; tr_ncas[k] = nCAS; tr_nwe[k] = nWE;
      tr_nta[k]  = nTA;  tr_busy[k] = busy; tr_ma[k]  = MA;
    end
  endtask

  task automatic test_reset();
    int bad;
    do_reset();
    n_checks++; if (nRAS !== 1'b1)  begin n_fail++; $display("FAIL rst_nras got %b exp 1", nRAS); end
    n_checks++; if (nCAS !== 4'hF)  begin n_fail++; $display("FAIL rst_ncas got %h exp F", nCAS); end
    n_checks++; if (nWE !== 1'b1)   begin n_fail++; $display("FAIL rst_nwe got %b exp 1", nWE); end
    n_checks++; if (nTA !== 1'b1)   begin n_fail++; $display("FAIL rst_nta got %b exp 1", nTA); end
    n_checks++; if (MA !== 11'h000) begin n_fail++; $display("FAIL rst_ma got %h exp 000", MA); end
    n_checks++; if (busy !== 1'b0)  begin n_fail++; $display("FAIL rst_busy got %b exp 0", busy); end
    // Reset in the middle of a line burst (first CPRE)
    issue(1'b1, 2'b11, 4'hF, 22'h0AB00E, 1'b1);
    repeat (4) @(negedge BCLK);
    RESET = 1'b1;
    @(negedge BCLK);
    n_checks++; if (nRAS !== 1'b1) begin n_fail++; $display("FAIL midrst_nras got %b exp 1", nRAS); end
    n_checks++; if (nCAS !== 4'hF) begin n_fail++; $display("FAIL midrst_ncas got %h exp F", nCAS); end
    n_checks++; if (nTA !== 1'b1)  begin n_fail++; $display("FAIL midrst_nta got %b exp 1", nTA); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got %b exp 0", busy); end
    @(negedge BCLK);
    RESET = 1'b0;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge BCLK);
      if (nTA !== 1'b1 || busy !== 1'b0 || nRAS !== 1'b1) bad++;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL postrst_quiet got %0d active cycles exp 0", bad); end
  endtask

  task automatic test_single_read();
    logic       e_nras, e_nta, e_busy;
    logic [3:0] e_ncas;
    do_reset();
    issue(1'b1, 2'b00, 4'hF, 22'h2A5C03, 1'b1);
    capture(8);
    for (int k = 1; k <= 8; k++) begin
      e_nras = (k <= 4) ? 1'b0 : 1'b1;
      e_ncas = (k == 3 || k == 4) ? 4'h0 : 4'hF;
      e_nta  = (k == 4) ? 1'b0 : 1'b1;
      e_busy = (k <= 6) ? 1'b1 : 1'b0;
      n_checks++; if (tr_nras[k] !== e_nras) begin n_fail++; $display("FAIL rd_nras c%0d got %b exp %b", k, tr_nras[k], e_nras); end
      n_checks++; if (tr_ncas[k] !== e_ncas) begin n_fail++; $display("FAIL rd_ncas c%0d got %h exp %h", k, tr_ncas[k], e_ncas); end
      n_checks++; if (tr_nta[k] !== e_nta)   begin n_fail++; $display("FAIL rd_nta c%0d got %b exp %b", k, tr_nta[k], e_nta); end
      n_checks++; if (tr_busy[k] !== e_busy) begin n_fail++; $display("FAIL rd_busy c%0d got %b exp %b", k, tr_busy[k], e_busy); end
      n_checks++; if (tr_nwe[k] !== 1'b1)    begin n_fail++; $display("FAIL rd_nwe c%0d got %b exp 1", k, tr_nwe[k]); end
    end
    for (int k = 1; k <= 2; k++) begin
      n_checks++; if (tr_ma[k] !== 11'h54B) begin n_fail++; $display("FAIL rd_row c%0d got %h exp 54b", k, tr_ma[k]); end
    end
    for (int k = 3; k <= 4; k++) begin
      n_checks++; if (tr_ma[k] !== 11'h403) begin n_fail++; $display("FAIL rd_col c%0d got %h exp 403", k, tr_ma[k]); end
    end
  endtask

  task automatic test_byte_write();
    logic       e_nwe, e_nta;
    logic [3:0] e_ncas;
    do_reset();
    issue(1'b0, 2'b01, 4'b0100, 22'h001234, 1'b1);
    capture(8);
    for (int k = 1; k <= 8; k++) begin
      e_ncas = (k == 3 || k == 4) ? 4'b1011 : 4'hF;
      e_nwe  = (k == 3 || k == 4) ? 1'b0 : 1'b1;
      e_nta  = (k == 4) ? 1'b0 : 1'b1;
      n_checks++; if (tr_ncas[k] !== e_ncas) begin n_fail++; $display("FAIL wr_ncas c%0d got %h exp %h", k, tr_ncas[k], e_ncas); end
      n_checks++; if (tr_nwe[k] !== e_nwe)   begin n_fail++; $display("FAIL wr_nwe c%0d got %b exp %b", k, tr_nwe[k], e_nwe); end
      n_checks++; if (tr_nta[k] !== e_nta)   begin n_fail++; $display("FAIL wr_nta c%0d got %b exp %b", k, tr_nta[k], e_nta); end
    end
    n_checks++; if (tr_ma[1] !== 11'h002) begin n_fail++; $display("FAIL wr_row got %h exp 002", tr_ma[1]); end
    n_checks++; if (tr_ma[3] !== 11'h234) begin n_fail++; $display("FAIL wr_col got %h exp 234", tr_ma[3]); end
  endtask

  task automatic test_line_read();
    logic        e_nras, e_nta, e_busy, cas_on;
    logic [3:0]  e_ncas;
    logic [10:0] e_col;
    int          pulses;
    do_reset();
    issue(1'b1, 2'b11, 4'hF, 22'h0AB00E, 1'b1);
    capture(16);
    pulses = 0;
    for (int k = 1; k <= 16; k++) begin
      cas_on = (k == 3 || k == 4 || k == 6 || k == 7 || k == 9 || k == 10 || k == 12 || k == 13);
      e_nras = (k <= 13) ? 1'b0 : 1'b1;
      e_ncas = cas_on ? 4'h0 : 4'hF;
      e_nta  = (k == 4 || k == 7 || k == 10 || k == 13) ? 1'b0 : 1'b1;
      e_busy = (k <= 15) ? 1'b1 : 1'b0;
      if (tr_nta[k] === 1'b0) pulses++;
      n_checks++; if (tr_nras[k] !== e_nras) begin n_fail++; $display("FAIL ln_nras c%0d got %b exp %b", k, tr_nras[k], e_nras); end
      n_checks++; if (tr_ncas[k] !== e_ncas) begin n_fail++; $display("FAIL ln_ncas c%0d got %h exp %h", k, tr_ncas[k], e_ncas); end
      n_checks++; if (tr_nta[k] !== e_nta)   begin n_fail++; $display("FAIL ln_nta c%0d got %b exp %b", k, tr_nta[k], e_nta); end
      n_checks++; if (tr_busy[k] !== e_busy) begin n_fail++; $display("FAIL ln_busy c%0d got %b exp %b", k, tr_busy[k], e_busy); end
      if (cas_on) begin
        if (k <= 4)       e_col = 11'h00E;
        else if (k <= 7)  e_col = 11'h00F;
        else if (k <= 10) e_col = 11'h00C;
        else              e_col = 11'h00D;
        n_checks++; if (tr_ma[k] !== e_col) begin n_fail++; $display("FAIL ln_col c%0d got %h exp %h", k, tr_ma[k], e_col); end
      end
    end
    n_checks++; if (tr_ma[1] !== 11'h156) begin n_fail++; $display("FAIL ln_row got %h exp 156", tr_ma[1]); end
    n_checks++; if (pulses != 4) begin n_fail++; $display("FAIL ln_pulses got %0d exp 4", pulses); end
  endtask

  task automatic test_decode_miss();
    int active;
    do_reset();
    issue(1'b1, 2'b00, 4'hF, 22'h2A5C03, 1'b0);
    capture(10);
    active = 0;
    for (int k = 1; k <= 10; k++)
      if (tr_nras[k] !== 1'b1 || tr_ncas[k] !== 4'hF || tr_nta[k] !== 1'b1 || tr_busy[k] !== 1'b0)
        active++;
    n_checks++; if (active != 0) begin n_fail++; $display("FAIL miss_quiet got %0d active cycles exp 0", active); end
  endtask

  task automatic test_refresh_and_collision();
    int          n;
    int          pulses;
    logic        e_nras, e_nta;
    logic [3:0]  e_ncas;
    do_reset();
    n = 0;
    while (!(nCAS === 4'h0 && nRAS === 1'b1) && n < 600) begin
      @(negedge BCLK); n++;
    end
    n_checks++; if (n != 390) begin n_fail++; $display("FAIL ref_first got %0d clks exp 390", n); end
    capture(9);
    for (int k = 1; k <= 9; k++) begin
      e_ncas = (k <= 5) ? 4'h0 : 4'hF;
      e_nras = (k >= 2 && k <= 5) ? 1'b0 : 1'b1;
      n_checks++; if (tr_ncas[k] !== e_ncas) begin n_fail++; $display("FAIL ref_ncas c%0d got %h exp %h", k, tr_ncas[k], e_ncas); end
      n_checks++; if (tr_nras[k] !== e_nras) begin n_fail++; $display("FAIL ref_nras c%0d got %b exp %b", k, tr_nras[k], e_nras); end
      n_checks++; if (tr_nwe[k] !== 1'b1)    begin n_fail++; $display("FAIL ref_nwe c%0d got %b exp 1", k, tr_nwe[k]); end
      n_checks++; if (tr_nta[k] !== 1'b1)    begin n_fail++; $display("FAIL ref_nta c%0d got %b exp 1", k, tr_nta[k]); end
    end
    n = 0;
    while (!(nCAS === 4'h0 && nRAS === 1'b1) && n < 600) begin
      @(negedge BCLK); n++;
    end
    n_checks++; if (n != 382) begin n_fail++; $display("FAIL ref_second got %0d clks exp 382", n); end
    // Line nTS up with the next expiry edge
    repeat (389) @(negedge BCLK);
    nTS = 1'b0; dramsel = 1'b1; RnW = 1'b1; SIZ = 2'b10; BE = 4'hF; ADDR = 22'h155555;
    @(negedge BCLK);
    nTS = 1'b1; dramsel = 1'b0;
    capture(15);
    pulses = 0;
    for (int k = 1; k <= 15; k++) begin
      e_ncas = (k <= 5 || k == 11 || k == 12) ? 4'h0 : 4'hF;
      e_nras = ((k >= 2 && k <= 5) || (k >= 9 && k <= 12)) ? 1'b0 : 1'b1;
      e_nta  = (k == 12) ? 1'b0 : 1'b1;
      if (tr_nta[k] === 1'b0) pulses++;
      n_checks++; if (tr_ncas[k] !== e_ncas) begin n_fail++; $display("FAIL col_ncas c%0d got %h exp %h", k, tr_ncas[k], e_ncas); end
      n_checks++; if (tr_nras[k] !== e_nras) begin n_fail++; $display("FAIL col_nras c%0d got %b exp %b", k, tr_nras[k], e_nras); end
      n_checks++; if (tr_nta[k] !== e_nta)   begin n_fail++; $display("FAIL col_nta c%0d got %b exp %b", k, tr_nta[k], e_nta); end
    end
    n_checks++; if (tr_busy[8] !== 1'b0)   begin n_fail++; $display("FAIL col_idle got %b exp 0", tr_busy[8]); end
    n_checks++; if (tr_ma[9] !== 11'h2AA)  begin n_fail++; $display("FAIL col_row got %h exp 2aa", tr_ma[9]); end
    n_checks++; if (tr_ma[11] !== 11'h555) begin n_fail++; $display("FAIL col_col got %h exp 555", tr_ma[11]); end
    n_checks++; if (tr_busy[15] !== 1'b0)  begin n_fail++; $display("FAIL col_done got %b exp 0", tr_busy[15]); end
    n_checks++; if (pulses != 1) begin n_fail++; $display("FAIL col_pulses got %0d exp 1", pulses); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_byte_write();
    test_line_read();
    test_decode_miss();
    test_refresh_and_collision();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
